// File: rtl/subleq_sequencer.sv
// Control FSM for the 8-bit SUBLEQ core.
// Fetches A, B, C and reads mem[A], mem[B]. Writes mem[B] - mem[A] back to mem[B].
// Branches to C on a result <= 0 and halts on a taken branch to HALT_ADDR.
// Optional feature: define SUBLEQ_ICNT_EN to add a 16-bit retired-instruction counter.
module subleq_sequencer #(
    parameter logic [7:0] START_PC  = 8'h00,
    parameter logic [7:0] HALT_ADDR = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [7:0]  pc_o,
    output logic        busy_o,
    output logic        halted_o,
    output logic        leq_o
`ifdef SUBLEQ_ICNT_EN
    ,
    output logic [15:0] instr_cnt_o
`endif
);

    typedef enum logic [3:0] {
        StIdle,
        StFetchA,
        StFetchB,
        StFetchC,
        StReadA,
        StReadB,
        StWriteB,
        StUpdate,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] c_q, c_d;
    logic [7:0] da_q, da_d;
    // Holds R = DB - DA; it is also the write data presented in WRITE_B.
    logic [7:0] r_q, r_d;
    logic       leq_q, leq_d;
    logic       halted_q, halted_d;
    logic       busy_q, busy_d;
    logic       req_q, req_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;

    logic       acked;
    logic       upd_leq;

    assign acked   = req_q & mem_ack_i;
    assign upd_leq = r_q[7] | (r_q == 8'h00);

`ifdef SUBLEQ_ICNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Retired-instruction counter, counts every UPDATE including the halting one.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StUpdate) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_cnt_o = cnt_q;
`endif

    // State, datapath and registered-output update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            pc_q     <= START_PC;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            c_q      <= 8'h00;
            da_q     <= 8'h00;
            r_q      <= 8'h00;
            leq_q    <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            da_q     <= da_d;
            r_q      <= r_d;
            leq_q    <= leq_d;
            halted_q <= halted_d;
            busy_q   <= busy_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
        end
    end

    // Next-state and datapath capture; memory states advance only on an acked edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        da_d    = da_q;
        r_d     = r_q;
        leq_d   = leq_q;
        unique case (state_q)
            StIdle: begin
                if (run_i) state_d = StFetchA;
            end
            StFetchA: begin
                if (acked) begin
                    a_d     = mem_rdata_i;
                    state_d = StFetchB;
                end
            end
            StFetchB: begin
                if (acked) begin
                    b_d     = mem_rdata_i;
                    state_d = StFetchC;
                end
            end
            StFetchC: begin
                if (acked) begin
                    c_d     = mem_rdata_i;
                    state_d = StReadA;
                end
            end
            StReadA: begin
                if (acked) begin
                    da_d    = mem_rdata_i;
                    state_d = StReadB;
                end
            end
            StReadB: begin
                if (acked) begin
                    r_d     = mem_rdata_i - da_q;
                    state_d = StWriteB;
                end
            end
            StWriteB: begin
                if (acked) state_d = StUpdate;
            end
            StUpdate: begin
                leq_d = upd_leq;
                if (upd_leq && (c_q == HALT_ADDR)) begin
                    state_d = StHalt;
                end else begin
                    pc_d    = upd_leq ? c_q : pc_q + 8'd3;
                    state_d = run_i ? StFetchA : StIdle;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered-output next values, derived from the state being entered.
    always_comb begin
        req_d    = 1'b0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        busy_d   = (state_d != StIdle) && (state_d != StHalt);
        halted_d = halted_q | (state_d == StHalt);
        unique case (state_d)
            StFetchA: begin
                req_d  = 1'b1;
                addr_d = pc_d;
            end
            StFetchB: begin
                req_d  = 1'b1;
                addr_d = pc_q + 8'd1;
            end
            StFetchC: begin
                req_d  = 1'b1;
                addr_d = pc_q + 8'd2;
            end
            StReadA: begin
                req_d  = 1'b1;
                addr_d = a_d;
            end
            StReadB: begin
                req_d  = 1'b1;
                addr_d = b_d;
            end
            StWriteB: begin
                req_d  = 1'b1;
                we_d   = 1'b1;
                addr_d = b_d;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = r_q;
    assign pc_o        = pc_q;
    assign busy_o      = busy_q;
    assign halted_o    = halted_q;
    assign leq_o       = leq_q;

endmodule

// File: tb/tb_subleq_sequencer.sv
// Bench for subleq_sequencer: memory model with configurable ACK latency and an
// instruction-level SUBLEQ reference model. Define SUBLEQ_ICNT_EN to check INSTR_CNT.
module tb_subleq_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic       busy, halted, leq;
`ifdef SUBLEQ_ICNT_EN
    logic [15:0] instr_cnt;
`endif

    logic [7:0] tb_mem  [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ref_pc = 8'h00;
    logic       ref_leq = 1'b0;
    logic       ref_halt = 1'b0;
    logic [7:0] ref_b = 8'h00;

    int         lat = 0;
    logic       blk_wr = 1'b0;
    int         wcnt = 0;
    logic [7:0] rd_log [$];
    int         wr_cnt = 0;
    int         last_r0 = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    subleq_sequencer #(
        .START_PC  (8'h00),
        .HALT_ADDR (8'hFF)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .run_i       (run),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .pc_o        (pc),
        .busy_o      (busy),
        .halted_o    (halted),
        .leq_o       (leq)
`ifdef SUBLEQ_ICNT_EN
        ,
        .instr_cnt_o (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory: ACK after `lat` wait cycles; writes can be withheld to test reset abandon.
    assign mem_ack   = mem_req && (wcnt >= lat) && !(blk_wr && mem_we);
    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                tb_mem[mem_addr] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_log.push_back(mem_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] val);
        tb_mem[addr]  = val;
        ref_mem[addr] = val;
    endtask

    // One SUBLEQ instruction at the reference level.
    task automatic ref_step();
        logic [7:0] p1, p2, a, b, c, r;
        p1 = ref_pc + 8'd1;
        p2 = ref_pc + 8'd2;
        a = ref_mem[ref_pc];
        b = ref_mem[p1];
        c = ref_mem[p2];
        r = ref_mem[b] - ref_mem[a];
        ref_mem[b] = r;
        ref_b = b;
        ref_leq = ($signed(r) <= 0);
        if (ref_leq && c == 8'hFF) ref_halt = 1'b1;
        else ref_pc = ref_leq ? c : ref_pc + 8'd3;
    endtask

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    // Start one instruction from IDLE, drop RUN after edge `drop`, wait for BUSY to fall.
    task automatic run_one(input int l, input int drop, input string tag);
        int edges;
        int w0;
        lat = l;
        w0 = wr_cnt;
        last_r0 = rd_log.size();
        ref_step();
        run = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        check({tag, "_req_after_idle"}, mem_req, 1);
        if (edges >= drop) run = 1'b0;
        while (busy && edges < 300) begin
            @(posedge clk); #1;
            edges++;
            if (edges >= drop) run = 1'b0;
        end
        check({tag, "_cycles"}, edges, 2 + 6 * (1 + l));
        check({tag, "_pc"}, pc, ref_pc);
        check({tag, "_leq"}, leq, ref_leq);
        check({tag, "_halted"}, halted, ref_halt);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_writes"}, wr_cnt - w0, 1);
        check({tag, "_reads"}, rd_log.size() - last_r0, 5);
        check({tag, "_mem"}, mem_diffs(), 0);
    endtask

    initial begin
        int reqs;
        int t;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            tb_mem[i]  = v;
            ref_mem[i] = v;
        end

        // Reset and idle
        rst_n = 1'b0;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_pc", pc, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_leq", leq, 0);
`ifdef SUBLEQ_ICNT_EN
        check("rst_icnt", instr_cnt, 0);
`endif
        rst_n = 1'b1;
        reqs = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mem_req || busy) reqs++;
        end
        check("idle_no_req", reqs, 0);

        // Non-branching instruction: 05 - 03 = 02
        poke(8'h00, 8'h10); poke(8'h01, 8'h11); poke(8'h02, 8'h40);
        poke(8'h10, 8'h03); poke(8'h11, 8'h05);
        run_one(0, 3, "nb");
        check("nb_mem11", tb_mem[8'h11], 8'h02);
        check("nb_pc03", pc, 8'h03);

        // RUN dropped in READ_A; self-referencing instruction branches to FE
        poke(8'h03, 8'h20); poke(8'h04, 8'h20); poke(8'h05, 8'hFE);
        run_one(0, 4, "rundrop");
        check("rundrop_mem20", tb_mem[8'h20], 8'h00);
        check("rundrop_pcfe", pc, 8'hFE);

        // PC wrap with two wait cycles per access
        poke(8'hFE, 8'h30); poke(8'hFF, 8'h31);
        poke(8'h30, 8'h01); poke(8'h31, 8'h05);
        run_one(2, 5, "wrap");
        check("wrap_fetch0", rd_log[last_r0], 8'hFE);
        check("wrap_fetch1", rd_log[last_r0 + 1], 8'hFF);
        check("wrap_fetch2", rd_log[last_r0 + 2], 8'h00);
        check("wrap_pc01", pc, 8'h01);

        // Signed boundary: 80 - 01 = 7F is positive
        poke(pc, 8'h50); poke(pc + 8'd1, 8'h51); poke(pc + 8'd2, 8'h60);
        poke(8'h50, 8'h01); poke(8'h51, 8'h80);
        run_one(1, 2, "signed");
        check("signed_mem51", tb_mem[8'h51], 8'h7F);

        // Random instructions, latencies and RUN drop points
        for (int k = 0; k < 14; k++) begin
            t = $urandom_range(0, 3);
            poke(ref_pc, 8'($urandom));
            poke(ref_pc + 8'd1, 8'($urandom));
            poke(ref_pc + 8'd2, 8'($urandom_range(0, 254)));
            run_one(t, $urandom_range(1, 1 + 6 * (1 + t)), "rand");
        end

        // Reset while WRITE_B is outstanding
        lat = 0;
        blk_wr = 1'b1;
        poke(ref_pc, 8'h70); poke(ref_pc + 8'd1, 8'h71); poke(ref_pc + 8'd2, 8'h00);
        poke(8'h70, 8'h01); poke(8'h71, 8'h09);
        run = 1'b1;
        t = 0;
        while (!(mem_req && mem_we) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("rstmid_reached_write", mem_req && mem_we, 1);
        rst_n = 1'b0;
        run = 1'b0;
        @(posedge clk); #1;
        check("rstmid_req", mem_req, 0);
        check("rstmid_pc", pc, 8'h00);
        check("rstmid_busy", busy, 0);
        check("rstmid_mem71", tb_mem[8'h71], 8'h09);
        check("rstmid_mem", mem_diffs(), 0);
        rst_n = 1'b1;
        blk_wr = 1'b0;
        ref_pc = 8'h00;
        ref_leq = 1'b0;

        // Taken branch to HALT_ADDR
        poke(8'h00, 8'h10); poke(8'h01, 8'h10); poke(8'h02, 8'hFF);
        run_one(0, 40, "halt");
        check("halt_mem10", tb_mem[8'h10], 8'h00);
        check("halt_flag", halted, 1);
        check("halt_leq", leq, 1);
        check("halt_pc", pc, 8'h00);
        run = 1'b1;
        reqs = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mem_req || busy) reqs++;
        end
        check("halt_stays", reqs, 0);
        check("halt_sticky", halted, 1);
`ifdef SUBLEQ_ICNT_EN
        check("halt_icnt", instr_cnt, 1);
`endif
        run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/subleq_sequencer.md
# subleq_sequencer

Control FSM for the 8-bit SUBLEQ core. Each instruction is three bytes (A, B, C) at PC, PC+1 and PC+2. The block fetches them, reads mem[A] and mem[B], and writes mem[B] − mem[A] back to mem[B]. It then branches to C when the result is ≤ 0, otherwise it advances PC by 3. It owns the program counter and is the only master of the single-port data/instruction memory.

## Interface
Parameters:
- START_PC, 8'h00, PC value loaded on reset.
- HALT_ADDR, 8'hFF, taken-branch target that halts the machine.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- RUN  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary.
- MEM_REQ  out  1  memory access request.
- MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ=1.
- MEM_ADDR  out  8  access address.
- MEM_WDATA  out  8  write data.
- MEM_RDATA  in  8  read data; valid in the cycle MEM_ACK=1.
- MEM_ACK  in  1  access complete; sampled only while MEM_REQ=1.
- PC  out  8  current program counter.
- BUSY  out  1  1 in any state other than IDLE and HALT.
- HALTED  out  1  sticky; set on entry to HALT.
- LEQ  out  1  ≤0 flag of the last executed instruction.
- INSTR_CNT  out  16  retired-instruction count; present only with SUBLEQ_ICNT_EN.

## Operation
- States: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B, UPDATE, HALT.
- IDLE → FETCH_A when RUN=1. Otherwise stays in IDLE.
- FETCH_A: read addr PC, capture into reg A.
- FETCH_B: read addr PC+1, capture into reg B.
- FETCH_C: read addr PC+2, capture into reg C.
- READ_A: read addr A, capture into reg DA.
- READ_B: read addr B, capture into reg DB.
- WRITE_B: write addr B, data R = DB − DA.
- Each memory state advances only on a CLK edge where MEM_REQ=1 and MEM_ACK=1. Until then it holds.
- UPDATE: no memory access. Sets LEQ = (R[7] | R==0).
  - If LEQ=1 and C == HALT_ADDR → HALT. PC is unchanged.
  - Else PC ← LEQ ? C : PC+3. Next state is FETCH_A if RUN=1, else IDLE.
- Arithmetic: 8-bit two's complement, modulo 256, no overflow detection. Example: 8'h80 − 8'h01 = 8'h7F, so LEQ=0.
- PC+1, PC+2 and PC+3 wrap modulo 256. Example: PC=8'hFE fetches FE, FF, 00, then next PC is 01.
- A self-referencing instruction is legal. With A==B, R=0, so LEQ=1.
- RUN deasserted mid-instruction: the current instruction completes through UPDATE, then the FSM enters IDLE.
- HALT exits only via reset. RUN is ignored in HALT.

## Timing
- Reset values: PC=START_PC, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, BUSY=0, HALTED=0, LEQ=0, INSTR_CNT=0, state IDLE.
- All outputs are registered.
- MEM_REQ rises on the cycle after entry to a memory state. MEM_ADDR, MEM_WE and MEM_WDATA are stable from then until the ACK edge.
- On the ACK edge the captured data is registered. In the following cycle, MEM_REQ is 1 with the next address, or 0 in UPDATE.
- Zero-wait memory (ACK tied to REQ): 1 cycle per access, 7 cycles per instruction (6 accesses + UPDATE). IDLE → first MEM_REQ takes 1 cycle.
- Each wait state adds one cycle per access.
- Reset asserted mid-access: the next edge forces the reset values. The outstanding request is abandoned, and the memory must tolerate this.
- HALTED and the LEQ/PC update take effect on the edge leaving UPDATE.

## Configuration
- SUBLEQ_ICNT_EN defined:
  - INSTR_CNT port and a 16-bit counter are present.
  - The counter increments on every UPDATE edge, including the halting instruction.
  - It wraps FFFF → 0000.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset/idle: hold RST_N=0 for 2 cycles, RUN=0 → all outputs at reset values, MEM_REQ stays 0 for 10 cycles.
- Non-branch: mem[00..02]=10,11,40; mem[10]=03; mem[11]=05; zero-wait; RUN=1 → mem[11]=02, LEQ=0, PC=03 after 7 cycles.
- Branch + halt:
  - mem[00..02]=10,10,FF → mem[10]=00, LEQ=1, HALTED=1, PC=00, MEM_REQ stays 0.
  - With SUBLEQ_ICNT_EN, INSTR_CNT=1.
- Wrap and wait states: START_PC=FE, ACK delayed 2 cycles per access → fetch addresses FE, FF, 00 in that order; 19 cycles per instruction; next PC=01 when not taken.
- RUN drop: deassert RUN during READ_A → the write to B still occurs, PC updates, then IDLE with BUSY=0.
- Reset mid-access: RST_N=0 during WRITE_B with ACK withheld → next edge MEM_REQ=0, PC=START_PC, memory unchanged.
